// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit path between NUM_REQ byte producers.
// Optional feature macro UART_TX_ARB_TAG_EN: each grant sends a {4'hA, index} header before the data byte.
module uart_tx_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int WIDTH      = 8,
    parameter  int GAP_CYCLES = 9000,
    localparam int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] din,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     tx_trigger,
    output logic [WIDTH-1:0]         tx_in,
    output logic                     busy,
    output logic [GW-1:0]            grant_id
);

    localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_HDR
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [GW-1:0]    r_grant_id;
    logic [GW-1:0]    w_winner;
    logic             w_found;
    logic [WIDTH-1:0] r_tx_in;
    logic [WIDTH-1:0] w_win_byte;
    logic [CW-1:0]    r_cnt;
`ifdef UART_TX_ARB_TAG_EN
    logic [WIDTH-1:0] r_data;
    logic             r_data_pend;
`endif

    // Search starts one past the last winner, so the last winner has lowest priority.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_found  = 1'b0;
        w_winner = r_grant_id;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && req[(int'(r_grant_id) + k) % NUM_REQ]) begin
                w_found  = 1'b1;
                w_winner = GW'((int'(r_grant_id) + k) % NUM_REQ);
            end
        end
    end

    assign w_win_byte = din[int'(w_winner)*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state and datapath registers use non-blocking assignments so all of them update together.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
`ifdef UART_TX_ARB_TAG_EN
                    w_next = S_HDR;
`else
                    w_next = S_SEND;
`endif
                end
            end
            S_HDR, S_SEND: w_next = S_GAP;
            S_GAP: begin
                if (r_cnt == '0) begin
`ifdef UART_TX_ARB_TAG_EN
                    w_next = r_data_pend ? S_SEND : S_IDLE;
`else
                    w_next = S_IDLE;
`endif
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_in    <= '0;
            r_grant_id <= GW'(NUM_REQ - 1);
            r_cnt      <= '0;
`ifdef UART_TX_ARB_TAG_EN
            r_data      <= '0;
            r_data_pend <= 1'b0;
`endif
        end else begin
            if (r_state == S_IDLE && w_found) begin
                r_grant_id <= w_winner;
`ifdef UART_TX_ARB_TAG_EN
                r_tx_in     <= WIDTH'({4'hA, 4'(w_winner)});
                r_data      <= w_win_byte;
                r_data_pend <= 1'b1;
`else
                r_tx_in <= w_win_byte;
`endif
            end
`ifdef UART_TX_ARB_TAG_EN
            // Header occupies tx_in until the data phase begins.
            if (r_state == S_GAP && w_next == S_SEND) begin
                r_tx_in <= r_data;
            end
            if (r_state == S_SEND) begin
                r_data_pend <= 1'b0;
            end
`endif
            if (r_state != S_GAP && w_next == S_GAP) begin
                r_cnt <= CW'(GAP_CYCLES - 1);
            end else if (r_state == S_GAP && r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign tx_trigger = (r_state == S_SEND) || (r_state == S_HDR);
    assign busy       = (r_state != S_IDLE);
    assign tx_in      = r_tx_in;
    assign grant_id   = r_grant_id;

    always_comb begin
        ack = '0;
        if (r_state == S_SEND) begin
            ack[r_grant_id] = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (NUM_REQ=4, WIDTH=8, GAP_CYCLES=4).
// Runs the tagged-header scenario instead of the single-byte ones when UART_TX_ARB_TAG_EN is defined.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int GAP = 4;

    typedef struct {
        logic [W-1:0] data;
        logic [N-1:0] ack;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] din;
    logic [N-1:0]   ack;
    logic           tx_trigger;
    logic [W-1:0]   tx_in;
    logic           busy;
    logic [1:0]     grant_id;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_push  = 0;
    int   n_trig  = 0;
    int   cyc     = 0;

    uart_tx_arbiter #(
        .NUM_REQ   (N),
        .WIDTH     (W),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .ack       (ack),
        .tx_trigger(tx_trigger),
        .tx_in     (tx_in),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_trigger === 1'b1) n_trig <= n_trig + 1;
    end

    task automatic push(input logic [W-1:0] data, input logic [N-1:0] ackv);
        exp_t e;
        e.data = data;
        e.ack  = ackv;
        sb.push_back(e);
        n_push++;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] data);
        din[i*W +: W] = data;
        req[i]        = 1'b1;
    endtask

    // Waits (bounded) for the next trigger and checks it against the scoreboard head.
    task automatic wait_trigger(input string name, output int t_seen);
        exp_t e;
        bit   seen;
        seen   = 1'b0;
        t_seen = -1000;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (tx_trigger === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: no tx_trigger within 40 cycles", name);
            return;
        end
        t_seen = cyc;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected tx_trigger with tx_in=%h", name, tx_in);
            return;
        end
        e = sb.pop_front();
        if (tx_in !== e.data) begin
            n_fail++;
            $display("FAIL %s tx_in: got %h expected %h", name, tx_in, e.data);
        end
        n_tests++;
        if (ack !== e.ack) begin
            n_fail++;
            $display("FAIL %s ack: got %b expected %b", name, ack, e.ack);
        end
    endtask

    task automatic check_spacing(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d cycles expected %0d", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_tests++;
        if (tx_trigger !== 1'b0 || tx_in !== 8'h00 || ack !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd3) begin
            n_fail++;
            $display("FAIL %s: trig=%b tx_in=%h ack=%b busy=%b grant_id=%0d expected 0,00,0000,0,3",
                     name, tx_trigger, tx_in, ack, busy, grant_id);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int trig_seen;
        rst = 1'b1;
        req = '0;
        din = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        rst = 1'b0;
        trig_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_trigger === 1'b1) trig_seen++;
        end
        check_spacing("reset_no_trigger_count", trig_seen, 0);
        check_reset_outputs("reset_idle_after_release");
    endtask

`ifndef UART_TX_ARB_TAG_EN
    task automatic test_single();
        int t_drive, t_trig, busy_cnt;
        @(negedge clk);
        set_req(2, 8'h5A);
        push(8'h5A, 4'b0100);
        t_drive = cyc;
        wait_trigger("single", t_trig);
        req[2] = 1'b0;
        check_spacing("single_latency", t_trig - t_drive, 1);
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        repeat (10) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
        end
        check_spacing("single_busy_cycles", busy_cnt, GAP + 1);
        n_tests++;
        if (tx_in !== 8'h5A || grant_id !== 2'd2 || ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_hold: tx_in=%h grant_id=%0d ack=%b expected 5a,2,0000", tx_in, grant_id, ack);
        end
    endtask

    task automatic test_round_robin();
        int t_prev, t_now;
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_req(i, 8'(8'h10 + i));
            push(8'(8'h10 + i), 4'(1 << i));
        end
        t_prev = 0;
        for (int k = 0; k < N; k++) begin
            wait_trigger($sformatf("rr_grant%0d", k), t_now);
            req[k] = 1'b0;
            if (k > 0) check_spacing($sformatf("rr_spacing%0d", k), t_now - t_prev, GAP + 2);
            t_prev = t_now;
        end
        repeat (GAP + 2) @(negedge clk);
    endtask

    task automatic test_mid_gap();
        int t3, t0, t1;
        @(negedge clk);
        set_req(3, 8'h33);
        push(8'h33, 4'b1000);
        wait_trigger("midgap_grant3", t3);
        req[3] = 1'b0;
        @(negedge clk);
        set_req(1, 8'h41);
        @(negedge clk);
        set_req(0, 8'h40);
        push(8'h40, 4'b0001);
        push(8'h41, 4'b0010);
        wait_trigger("midgap_grant0", t0);
        req[0] = 1'b0;
        check_spacing("midgap_spacing0", t0 - t3, GAP + 2);
        wait_trigger("midgap_grant1", t1);
        req[1] = 1'b0;
        check_spacing("midgap_spacing1", t1 - t0, GAP + 2);
        repeat (GAP + 2) @(negedge clk);
    endtask

    task automatic test_reset_mid_gap();
        int t0, t_rel, t22;
        @(negedge clk);
        set_req(0, 8'h20);
        push(8'h20, 4'b0001);
        wait_trigger("rstgap_first", t0);
        req[0] = 1'b0;
        set_req(2, 8'h22);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rstgap_async_clear");
        @(negedge clk);
        check_reset_outputs("rstgap_held");
        rst   = 1'b0;
        t_rel = cyc;
        push(8'h22, 4'b0100);
        wait_trigger("rstgap_resend", t22);
        req[2] = 1'b0;
        check_spacing("rstgap_latency", t22 - t_rel, 1);
        repeat (GAP + 2) @(negedge clk);
    endtask
`else
    task automatic test_tag();
        int t_hdr, t_data, ack_between;
        do_reset();
        set_req(1, 8'h77);
        push(8'hA1, 4'b0000);
        push(8'h77, 4'b0010);
        wait_trigger("tag_header", t_hdr);
        ack_between = 0;
        wait_trigger("tag_data", t_data);
        req[1] = 1'b0;
        check_spacing("tag_spacing", t_data - t_hdr, GAP + 1);
        repeat (GAP + 2) begin
            @(negedge clk);
            if (ack !== 4'b0000) ack_between++;
        end
        check_spacing("tag_no_extra_ack", ack_between, 0);
    endtask
`endif

    initial begin
        rst = 1'b1;
        req = '0;
        din = '0;
        test_reset();
`ifndef UART_TX_ARB_TAG_EN
        test_single();
        test_round_robin();
        test_mid_gap();
        test_reset_mid_gap();
`else
        test_tag();
`endif
        repeat (10) @(negedge clk);
        n_tests++;
        if (n_trig !== n_push || sb.size() != 0) begin
            n_fail++;
            $display("FAIL trigger_total: got %0d triggers expected %0d (pending %0d)", n_trig, n_push, sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
